// File: rtl/keypad_pkg.sv
// Shared widths and FSM state type for the keypad debounce/encode front end.
// Pure declarations; no logic, no latency, no flow control.
package keypad_pkg;

   localparam int KEY_W   = 10;
   localparam int DIGIT_W = 4;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } state_t;

endpackage

// File: rtl/keypad_onehot_enc.sv
// One-hot keypad to BCD encoder with zero/single/multi-key classification.
// Purely combinational (zero latency); no flow control, the result follows the input.
module keypad_onehot_enc
   import keypad_pkg::*;
(
   input  logic [KEY_W-1:0]   keys,
   output logic [DIGIT_W-1:0] bcd,
   output logic               is_zero,
   output logic               is_valid,
   output logic               is_multi
);

   logic [3:0] ones;

   // bcd is only meaningful when exactly one bit is set
   always_comb begin
      ones = '0;
      bcd  = '0;
      for (int i = 0; i < KEY_W; i++) begin
         if (keys[i]) begin
            ones = ones + 4'd1;
            bcd  = DIGIT_W'(i);
         end
      end
      is_zero  = (ones == 4'd0);
      is_valid = (ones == 4'd1);
      is_multi = (ones > 4'd1);
   end

endmodule

// File: rtl/keypad_debounce_encoder.sv
// Synchronise, debounce and BCD-encode a 10-key keypad; one digit strobe per clean press, optional key_err under KEYPAD_ERR_EN.
// Strobe DEBOUNCE_CYCLES+2 cycles after a stable raw press; no backpressure, a press accepted while enable=0 is dropped.
module keypad_debounce_encoder
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20,
   parameter int RELEASE_CYCLES  = 20
) (
   input  logic               clock,
   input  logic               clear,
   input  logic [KEY_W-1:0]   keypad,
   input  logic               enable,
   output logic [DIGIT_W-1:0] digit,
   output logic               digit_valid,
   output logic               key_down
`ifdef KEYPAD_ERR_EN
   ,
   output logic               key_err
`endif
);

   localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] REL_CNT = CNT_W'(RELEASE_CYCLES);

   state_t             state;
   logic [KEY_W-1:0]   sync1;
   logic [KEY_W-1:0]   ks;
   logic [KEY_W-1:0]   cand;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_inc;
   logic [DIGIT_W-1:0] ks_bcd;
   logic               ks_zero;
   logic               ks_valid;
   logic               ks_multi;
   logic               accept;
   logic               release_done;

   keypad_onehot_enc u_enc (
      .keys     (ks),
      .bcd      (ks_bcd),
      .is_zero  (ks_zero),
      .is_valid (ks_valid),
      .is_multi (ks_multi)
   );

   assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

   // A count of 1 completes on the very cycle the wait would otherwise start
   always_comb begin
      accept       = 1'b0;
      release_done = 1'b0;
      case (state)
         IDLE:       accept       = ks_valid && (DEB_CNT <= CNT_W'(1));
         PRESS_WAIT: accept       = ks_valid && (ks == cand) && (cnt_inc >= DEB_CNT);
         HELD:       release_done = ks_zero && (REL_CNT <= CNT_W'(1));
         REL_WAIT:   release_done = ks_zero && (cnt_inc >= REL_CNT);
         default:    ;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state       <= IDLE;
         sync1       <= '0;
         ks          <= '0;
         cand        <= '0;
         cnt         <= '0;
         digit       <= '0;
         digit_valid <= 1'b0;
         key_down    <= 1'b0;
      end else begin
         sync1       <= keypad;
         ks          <= sync1;
         digit_valid <= 1'b0;
         if (accept) begin
            state       <= HELD;
            cnt         <= '0;
            digit       <= ks_bcd;
            key_down    <= 1'b1;
            digit_valid <= enable;
         end else if (release_done) begin
            state    <= IDLE;
            cnt      <= '0;
            key_down <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (ks_valid) begin
                     state <= PRESS_WAIT;
                     cand  <= ks;
                     cnt   <= CNT_W'(1);
                  end
               end
               PRESS_WAIT: begin
                  if (!ks_valid) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (ks != cand) begin
                     cand <= ks;
                     cnt  <= CNT_W'(1);
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               HELD: begin
                  if (ks_zero) begin
                     state <= REL_WAIT;
                     cnt   <= CNT_W'(1);
                  end
               end
               REL_WAIT: begin
                  if (!ks_zero) begin
                     state <= HELD;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef KEYPAD_ERR_EN
   logic err_armed;

   // One error pulse per multi-key episode; re-armed only by an all-clear keypad
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         key_err   <= 1'b0;
         err_armed <= 1'b1;
      end else begin
         key_err <= 1'b0;
         if (ks_zero) begin
            err_armed <= 1'b1;
         end else if (ks_multi && err_armed && (state == IDLE || state == PRESS_WAIT)) begin
            key_err   <= 1'b1;
            err_armed <= 1'b0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder: vector table, corner sequences and a randomized run against a run-length model.
module tb_keypad_debounce_encoder;

   localparam int D = 20;
   localparam int R = 20;

   logic       clock = 1'b0;
   logic       clear;
   logic [9:0] keypad;
   logic       enable;
   logic [3:0] digit;
   logic       digit_valid;
   logic       key_down;
`ifdef KEYPAD_ERR_EN
   logic       key_err;
`endif

   int total = 0;
   int bad   = 0;
   int pulses, kd_seen, errs;

   keypad_debounce_encoder #(.DEBOUNCE_CYCLES(D), .RELEASE_CYCLES(R)) dut (
      .clock       (clock),
      .clear       (clear),
      .keypad      (keypad),
      .enable      (enable),
      .digit       (digit),
      .digit_valid (digit_valid),
      .key_down    (key_down)
`ifdef KEYPAD_ERR_EN
      ,
      .key_err     (key_err)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [9:0] key;
      logic       en;
      int         hold;
      int         exp_pulses;
      int         exp_digit;
      int         exp_kd;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Drive at the falling edge, let one rising edge pass, sample on the next falling edge
   task automatic step(input logic [9:0] k, input logic en);
      keypad = k;
      enable = en;
      @(posedge clock);
      @(negedge clock);
      if (digit_valid) pulses++;
      if (key_down) kd_seen = 1;
`ifdef KEYPAD_ERR_EN
      if (key_err) errs++;
`endif
   endtask

   task automatic clear_counts();
      pulses = 0;
      kd_seen = 0;
      errs = 0;
   endtask

   // Reference model: acceptance from run lengths of the twice-delayed keypad
   logic [9:0] m_d1, m_d2, m_runval;
   int         m_run, m_zrun, m_digit;
   bit         m_held, m_dv, m_armed, m_err;

   task automatic model_reset();
      m_d1 = '0; m_d2 = '0; m_runval = '0;
      m_run = 0; m_zrun = 0; m_digit = 0;
      m_held = 0; m_dv = 0; m_armed = 1; m_err = 0;
   endtask

   task automatic model_edge(input logic [9:0] raw, input logic en);
      logic [9:0] k;
      int         n;
      k = m_d2;
      n = $countones(k);
      m_dv = 0;
      m_err = 0;
      if (k == m_runval) m_run++;
      else begin
         m_runval = k;
         m_run = 1;
      end
      if (k == 0) m_zrun++;
      else m_zrun = 0;
      if (k == 0) m_armed = 1;
      else if (n > 1 && m_armed && !m_held) begin
         m_err = 1;
         m_armed = 0;
      end
      if (!m_held && n == 1 && m_run == D) begin
         m_held = 1;
         m_dv = en;
         for (int b = 0; b < 10; b++) if (k[b]) m_digit = b;
      end else if (m_held && k == 0 && m_zrun == R) begin
         m_held = 0;
      end
      m_d2 = m_d1;
      m_d1 = raw;
   endtask

   task automatic rand_cycle(input logic [9:0] k, input logic en);
      keypad = k;
      enable = en;
      @(posedge clock);
      model_edge(k, en);
      @(negedge clock);
      check("rand_digit_valid", int'(digit_valid), int'(m_dv));
      check("rand_key_down", int'(key_down), int'(m_held));
      check("rand_digit", int'(digit), m_digit);
`ifdef KEYPAD_ERR_EN
      check("rand_key_err", int'(key_err), int'(m_err));
`endif
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      #1;
      check("clear_digit_valid", int'(digit_valid), 0);
      check("clear_key_down", int'(key_down), 0);
      check("clear_digit", int'(digit), 0);
      #1;
      clear = 1'b0;
   endtask

   initial begin
      int lat, rel, first, ep_len, ep_type, b1, b2;
      logic [9:0] k, k2;
      logic en;

      vecs[0] = '{10'h004, 1'b1, 110, 1, 2, 1};
      vecs[1] = '{10'h020, 1'b1, 110, 1, 5, 1};
      vecs[2] = '{10'h200, 1'b1,  60, 1, 9, 1};
      vecs[3] = '{10'h001, 1'b1,  60, 1, 0, 1};
      vecs[4] = '{10'h201, 1'b1, 100, 0, 0, 0};
      vecs[5] = '{10'h080, 1'b0,  60, 0, 7, 1};
      vecs[6] = '{10'h008, 1'b1,  19, 0, 7, 0};
      vecs[7] = '{10'h008, 1'b1,  20, 1, 3, 1};
      vecs[8] = '{10'h010, 1'b1,  60, 1, 4, 1};

      keypad = '0;
      enable = 1'b1;
      clear  = 1'b1;
      #2;
      check("reset_digit_valid", int'(digit_valid), 0);
      check("reset_key_down", int'(key_down), 0);
      check("reset_digit", int'(digit), 0);
`ifdef KEYPAD_ERR_EN
      check("reset_key_err", int'(key_err), 0);
`endif
      @(negedge clock);
      clear = 1'b0;

      for (int i = 0; i < 9; i++) begin
         clear_counts();
         repeat (vecs[i].hold) step(vecs[i].key, vecs[i].en);
         repeat (45) step('0, vecs[i].en);
         check($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
         check($sformatf("vec%0d_digit", i), int'(digit), vecs[i].exp_digit);
         check($sformatf("vec%0d_key_down_seen", i), kd_seen, vecs[i].exp_kd);
         check($sformatf("vec%0d_key_down_after", i), int'(key_down), 0);
`ifdef KEYPAD_ERR_EN
         check($sformatf("vec%0d_key_err", i), errs, ($countones(vecs[i].key) > 1) ? 1 : 0);
`endif
      end

      // Exact press latency and release timing
      clear_counts();
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         step(10'h040, 1'b1);
         if (digit_valid) begin
            lat = n;
            break;
         end
      end
      check("press_latency", lat, D + 2);
      check("press_digit", int'(digit), 6);
      repeat (20) step(10'h040, 1'b1);
      check("press_single_pulse", pulses, 1);
      rel = -1;
      for (int n = 1; n <= 60; n++) begin
         step('0, 1'b1);
         if (!key_down) begin
            rel = n;
            break;
         end
      end
      check("release_latency", rel, R + 2);

      // Enable low during the press, raised while still held
      clear_counts();
      repeat (40) step(10'h080, 1'b0);
      check("gate_key_down", int'(key_down), 1);
      check("gate_digit", int'(digit), 7);
      repeat (30) step(10'h080, 1'b1);
      check("gate_no_pulse", pulses, 0);
      check("gate_still_down", int'(key_down), 1);
      repeat (45) step('0, 1'b1);
      check("gate_released", int'(key_down), 0);

      // Press bounce then release bounce
      clear_counts();
      first = -1;
      for (int n = 1; n <= 130; n++) begin
         k = (n > 30 || ((n - 1) / 3) % 2 == 0) ? 10'h020 : 10'h000;
         step(k, 1'b1);
         if (digit_valid && first < 0) first = n;
      end
      check("bounce_first_pulse", first, 30 + 1 + D + 1);
      for (int n = 1; n <= 10; n++) step((((n - 1) / 3) % 2 == 0) ? 10'h000 : 10'h020, 1'b1);
      repeat (45) step('0, 1'b1);
      check("bounce_pulses", pulses, 1);
      check("bounce_digit", int'(digit), 5);
      check("bounce_released", int'(key_down), 0);

      // clear pulse ten cycles into the press wait
      clear_counts();
      repeat (12) step(10'h100, 1'b1);
      pulse_clear();
      lat = -1;
      for (int n = 1; n <= 60; n++) begin
         step(10'h100, 1'b1);
         if (digit_valid) begin
            lat = n;
            break;
         end
      end
      check("post_clear_latency", lat, D + 2);
      check("post_clear_digit", int'(digit), 8);
      repeat (45) step('0, 1'b1);

      // Randomized episodes against the model
      keypad = '0;
      pulse_clear();
      model_reset();
      for (int ep = 0; ep < 70; ep++) begin
         ep_type = int'($urandom_range(0, 4));
         ep_len  = int'($urandom_range(3, 45));
         en      = ($urandom_range(0, 3) != 0);
         b1      = int'($urandom_range(0, 9));
         b2      = (b1 + int'($urandom_range(1, 9))) % 10;
         k       = 10'(1) << b1;
         k2      = 10'(1) << b2;
         for (int c = 0; c < ep_len; c++) begin
            case (ep_type)
               0: rand_cycle(k, en);
               1: rand_cycle(($urandom_range(0, 4) == 0) ? 10'h000 : k, en);
               2: rand_cycle(k | k2, en);
               3: rand_cycle((c < ep_len / 2) ? k : k2, en);
               default: rand_cycle(($urandom_range(0, 5) == 0) ? k : 10'h000, en);
            endcase
         end
         repeat (int'($urandom_range(0, 30))) rand_cycle('0, en);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/keypad_debounce_encoder.md
Name: keypad_debounce_encoder

Overview:
- Front-end stage directly upstream of the microwave timer's digit-entry logic.
- Synchronizes and debounces the raw 10-bit one-hot keypad and encodes the pressed key to BCD.
- Emits exactly one single-cycle digit strobe per clean press, which the timer shifts into its mm:ss entry register.
- Multi-key presses and release bounce never generate strobes.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable synchronized cycles needed to accept a press (1..255).
- RELEASE_CYCLES, 20: consecutive all-zero synchronized cycles needed to accept a release (1..255).

Ports:
- clock  input  1  system clock (10 us period in system benches).
- clear  input  1  asynchronous active-high reset.
- keypad  input  10  raw keys; bit n = digit n; asynchronous to clock; may bounce.
- enable  input  1  timer is accepting digits (low while cooking).
- digit  output  4  BCD of last accepted key; holds until the next accept.
- digit_valid  output  1  one-cycle strobe; digit is valid in the same cycle.
- key_down  output  1  a debounced key is currently held.

Behaviour:
- Reset (clear=1, async): state IDLE; counter=0; both sync stages=0; digit=4'd0; digit_valid=0; key_down=0; key_err=0 if present. Outputs must be at reset values immediately, not at the next edge.
- Synchronizer: 2-flop on all 10 bits; ks = second stage. The FSM sees only ks.
- Key classification of ks: zero = all bits 0; valid = exactly one bit set; multi = two or more bits set.
- IDLE:
  - ks valid -> PRESS_WAIT; cand<=ks; cnt<=1.
  - ks multi or zero -> stay in IDLE.
- PRESS_WAIT:
  - ks==cand -> cnt+1.
  - ks valid but !=cand -> cand<=ks; cnt<=1 (restart).
  - ks zero or multi -> IDLE.
  - When cnt reaches DEBOUNCE_CYCLES -> HELD; digit<=enc(cand); key_down<=1; digit_valid<=enable for that one cycle.
- HELD:
  - ks zero -> REL_WAIT; cnt<=1.
  - Any other ks, including extra keys, is ignored.
- REL_WAIT:
  - ks nonzero -> HELD; cnt cleared.
  - ks zero -> cnt+1.
  - When cnt reaches RELEASE_CYCLES -> IDLE; key_down<=0.
- Latency: raw keypad stable before edge k -> digit_valid high in the cycle after edge k+1+DEBOUNCE_CYCLES.
- A press accepted while enable=0 is consumed: no strobe, even if enable rises while the key is still held.
- digit and key_down are registered. digit_valid never stays high two cycles in a row.
- Counter is 8 bits and saturates; it never wraps.
- clear mid-press aborts the press. The first press after clear deasserts needs the full debounce again.

Optional Feature:
- Macro: KEYPAD_ERR_EN.
- Defined:
  - Adds output key_err (1 bit).
  - key_err is a one-cycle pulse when ks goes multi while in IDLE or PRESS_WAIT.
  - No further pulse until ks returns to zero.
  - Reset value 0.
- Undefined: port absent; multi-key presses are silently rejected as described above.

Decomposition:
- Package keypad_pkg holds:
  - state enum {IDLE, PRESS_WAIT, HELD, REL_WAIT};
  - KEY_W=10, DIGIT_W=4, CNT_W=8.
- Sub-module keypad_onehot_enc: combinational 10-bit one-hot to 4-bit BCD encoder plus is_zero, is_valid and is_multi flags. It is instantiated on ks and reused by the timer bench checker.

Test Plan (DEBOUNCE_CYCLES=RELEASE_CYCLES=20, 10 us clock):
1. Clean press: keypad=10'b0000000100 held 1100 us, then 0, enable=1 -> one digit_valid pulse with digit=4'd2 exactly 22 cycles after the change; key_down high until 20 cycles after ks clears; no second pulse.
2. Sequence 5, 9, 0, 0, each held 1100 us with 1100 us gaps -> strobes with digit 5, 9, 0, 0 in order; exactly 4 pulses.
3. Bounce: keypad toggles 10'b0000100000 / 0 every 30 us for 300 us, then stable 1 ms -> single strobe with digit=4'd5, only after 20 stable cycles; release bounce of 100 us -> no extra strobe.
4. Multi-key: keypad=10'b1000000001 for 1 ms -> no digit_valid and key_down=0. With KEYPAD_ERR_EN defined, key_err pulses exactly once.
5. Enable gating: enable=0 during a press of 7 -> no strobe, digit=4'd7 and key_down=1; raising enable while held -> still no strobe.
6. Reset mid-press: clear pulsed 1 us at cycle 10 of PRESS_WAIT -> outputs at reset values immediately; key still held -> strobe occurs 22 cycles after clear falls.
